// File: rtl/line_memory_responder.sv
// Whole-line backing store for the data-cache miss path: fixed-latency read refill
// and write-back, completion signalled by a one-cycle ack pulse.
module line_memory_responder #(
  parameter int LINE_W    = 256,
  parameter int MEM_LINES = 512,
  parameter int IDX_W     = 9,
  parameter int LATENCY   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              wr_r;
  logic [IDX_W-1:0]  idx_r;
  logic [LINE_W-1:0] wdata_r;
  logic [LINE_W-1:0] mem_r [MEM_LINES];
  logic              commit_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  // Write-back commits on the same edge that raises ack.
  always_comb begin
    commit_s = 1'b0;
    if ((state_r == WAIT) && (cnt_r == '0) && wr_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Line array; a reset arriving on the commit edge discards the write.
  always_ff @(posedge clk_i) begin
    if (commit_s && !rst_i) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Request FSM with registered ack, read data and busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_o  <= 1'b0;
          data_o <= '0;
          if (enable_i) begin
            wr_r    <= write_i;
            idx_r   <= addr_i[5+IDX_W-1:5];
            wdata_r <= data_i;
            cnt_r   <= CNT_LOAD;
            state_r <= WAIT;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        WAIT: begin
          busy_o <= 1'b1;
          if (cnt_r == '0) begin
            ack_o   <= 1'b1;
            data_o  <= wr_r ? '0 : mem_r[idx_r];
            state_r <= ACK;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        ACK: begin
          // enable_i is deliberately not sampled here so a lingering request cannot retrigger.
          ack_o   <= 1'b0;
          data_o  <= '0;
          busy_o  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack_o   <= 1'b0;
          data_o  <= '0;
          busy_o  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Backing-store responder on the far side of the data-cache miss path.
- Services whole-line (256-bit) read-refill and write-back requests from the cache controller.
- Fixed access latency; completion signalled by a one-cycle ack pulse.
- Models the main data memory the cache-line SRAM refills from and evicts dirty lines to.

Parameters:
- LINE_W, 256, line width in bits; equals the cache data line.
- MEM_LINES, 512, number of stored lines; power of two.
- IDX_W, 9, line-index width; log2(MEM_LINES).
- LATENCY, 10, cycles from request acceptance to ack; minimum 1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  request valid; held by the controller until ack_o is seen.
- write_i  input  1  1 = write-back line, 0 = read line; qualified by enable_i.
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[5+IDX_W-1:5].
- data_i  input  LINE_W  write-back line data.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  LINE_W  read line data; valid only while ack_o=1 for a read.
- busy_o  output  1  high while a request is in flight (WAIT or ACK).

Behaviour:
- Reset values: state IDLE, ack_o=0, data_o=0, busy_o=0, latency counter 0. Array contents are not touched by reset.
- Reset mid-operation aborts the request; a pending write is discarded (no array update).
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On a rising edge with enable_i=1, latch write_i, line index and data_i; load counter with LATENCY-1; go to WAIT.
  - Address bits above the index are ignored, so addresses alias modulo MEM_LINES lines.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 0: assert ack_o and go to ACK.
  - For a read, data_o is loaded from the latched index on that same edge.
  - For a write, the array line is written with the latched data on that same edge, and data_o=0.
- ACK:
  - ack_o is high for exactly this one cycle.
  - Next edge: ack_o=0, data_o=0, go to IDLE.
  - enable_i is ignored in ACK. A controller that is slow to drop enable_i cannot retrigger until IDLE is sampled.
- Timing: acceptance at edge k gives ack_o high from edge k+LATENCY to edge k+LATENCY+1. The earliest next acceptance is edge k+LATENCY+2.
- Input changes after acceptance (addr_i, data_i, write_i, enable_i) have no effect on the in-flight request.
- busy_o = (state != IDLE), registered with the state.
- Read-after-write to the same line in consecutive requests returns the newly written data, because the write commits at the ack edge.
- data_o is driven only from registers and is 0 whenever ack_o=0.

Test Plan:
- Write then read, LATENCY=10:
  - Reset, then write addr 0x0000_0420 with data {8{32'hDEAD_BEEF}} → ack_o high exactly 10 cycles after acceptance, for one cycle; data_o=0 during that ack.
  - Then read 0x0000_0420 → ack after 10 cycles with data_o={8{32'hDEAD_BEEF}}.
- Offset and alias:
  - Read 0x0000_043F after the write above → same line returned (low bits ignored).
  - Write 0x0000_0000 with 256'h1, then read 0x0000_4000 (index wraps at 512 lines) → data_o=256'h1.
- Held enable: keep enable_i=1 continuously for 30 cycles with a read to 0x20 → ack pulses at cycles 10 and 22 after the first acceptance, never on consecutive cycles; busy_o=0 only in the IDLE cycles between requests.
- Input change mid-request: accept a write to 0x40 with data A, change data_i to B and addr_i to 0x60 on the next cycle → reading 0x40 returns A and reading 0x60 returns its prior value.
- Reset mid-write: accept a write of 256'h5 to 0x80 over old value 256'h9, assert rst_i at cycle 4 → ack_o, busy_o and data_o go to 0 immediately and no ack occurs; a subsequent read of 0x80 returns 256'h9.
- LATENCY=1 build: read accepted at edge k → ack_o high between edges k+1 and k+2; next accept at edge k+3.
